// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: control path of a 5-stage in-order pipeline.
// Carries decoded control fields through the ID/EX, EX/MEM and MEM/WB
// registers. It also produces the hazard controls (load-use stall, branch
// flush) and the EX operand forwarding selects.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   id_valid            decode stage holds a real instruction
//   id_ctrl[7:0]        {regwrite, resultsrc[1:0], memwrite, alusrc, aluop[1:0], branch}
//   id_rs1, id_rs2      decode source register indices
//   id_rd               decode destination register index
//   ex_zero             ALU zero flag for the instruction in EX
//   ex_alusrc, ex_aluop EX operand-B select and ALU operation class
//   mem_memwrite        data-memory write enable
//   mem_regwrite/mem_rd MEM-stage writeback intent and destination
//   wb_regwrite/wb_resultsrc/wb_rd  register-file write controls
//   pcsrc_e             branch taken in EX, redirect PC
//   stall_fd            hold PC and IF/ID register
//   flush_d             invalidate IF/ID register
//   fwd_a, fwd_b        operand forward select: 00 regfile, 01 WB, 10 MEM
module ctrl_pipeline #(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [7:0]    id_ctrl,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic          ex_zero,
  output logic          ex_alusrc,
  output logic [1:0]    ex_aluop,
  output logic          mem_memwrite,
  output logic          mem_regwrite,
  output logic [RW-1:0] mem_rd,
  output logic          wb_regwrite,
  output logic [1:0]    wb_resultsrc,
  output logic [RW-1:0] wb_rd,
  output logic          pcsrc_e,
  output logic          stall_fd,
  output logic          flush_d,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic [1:0]    resultsrc;
    logic          memwrite;
    logic          alusrc;
    logic [1:0]    aluop;
    logic          branch;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
  } idex_t;

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic [1:0]    resultsrc;
    logic          memwrite;
    logic [RW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic [1:0]    resultsrc;
    logic [RW-1:0] rd;
  } memwb_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic load_use;
  logic bubble_id;

  // Load in EX whose destination is read by the instruction in ID.
  assign load_use = idex_q.valid && (idex_q.resultsrc == 2'b01) &&
                    (idex_q.rd != '0) && id_valid &&
                    ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));

  assign pcsrc_e  = idex_q.valid & idex_q.branch & ex_zero;
  assign flush_d  = pcsrc_e;
  // A taken branch discards the ID instruction, so stalling it is pointless.
  assign stall_fd = load_use & ~pcsrc_e;

  assign bubble_id = ~id_valid | load_use | pcsrc_e;

  always_comb begin
    idex_d = '0;
    if (!bubble_id) begin
      idex_d.valid     = 1'b1;
      idex_d.regwrite  = id_ctrl[7];
      idex_d.resultsrc = id_ctrl[6:5];
      idex_d.memwrite  = id_ctrl[4];
      idex_d.alusrc    = id_ctrl[3];
      idex_d.aluop     = id_ctrl[2:1];
      idex_d.branch    = id_ctrl[0];
      idex_d.rd        = id_rd;
      idex_d.rs1       = id_rs1;
      idex_d.rs2       = id_rs2;
    end
  end

  // Bubbles carry all-zero fields, so the later stages copy straight through.
  always_comb begin
    exmem_d           = '0;
    exmem_d.valid     = idex_q.valid;
    exmem_d.regwrite  = idex_q.regwrite;
    exmem_d.resultsrc = idex_q.resultsrc;
    exmem_d.memwrite  = idex_q.memwrite;
    exmem_d.rd        = idex_q.rd;
  end

  always_comb begin
    memwb_d           = '0;
    memwb_d.valid     = exmem_q.valid;
    memwb_d.regwrite  = exmem_q.regwrite;
    memwb_d.resultsrc = exmem_q.resultsrc;
    memwb_d.rd        = exmem_q.rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  logic mem_fwd_ok;
  logic wb_fwd_ok;

  assign mem_fwd_ok = exmem_q.valid & exmem_q.regwrite & (exmem_q.rd != '0);
  assign wb_fwd_ok  = memwb_q.valid & memwb_q.regwrite & (memwb_q.rd != '0);

  // MEM holds the younger result, so it takes priority over WB.
  always_comb begin
    fwd_a = 2'b00;
    if (mem_fwd_ok && (exmem_q.rd == idex_q.rs1))     fwd_a = 2'b10;
    else if (wb_fwd_ok && (memwb_q.rd == idex_q.rs1)) fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_fwd_ok && (exmem_q.rd == idex_q.rs2))     fwd_b = 2'b10;
    else if (wb_fwd_ok && (memwb_q.rd == idex_q.rs2)) fwd_b = 2'b01;
  end

  assign ex_alusrc    = idex_q.valid & idex_q.alusrc;
  assign ex_aluop     = idex_q.valid ? idex_q.aluop : 2'b00;
  assign mem_memwrite = exmem_q.valid & exmem_q.memwrite;
  assign mem_regwrite = exmem_q.valid & exmem_q.regwrite;
  assign mem_rd       = exmem_q.rd;
  assign wb_regwrite  = memwb_q.valid & memwb_q.regwrite;
  assign wb_resultsrc = memwb_q.valid ? memwb_q.resultsrc : 2'b00;
  assign wb_rd        = memwb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Testbench for ctrl_pipeline: a table of per-cycle ID inputs and expected
// outputs, plus hand-written reset sequences.
module tb_ctrl_pipeline;

  localparam int RW = 5;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [7:0]    id_ctrl;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          ex_zero;
  logic          ex_alusrc;
  logic [1:0]    ex_aluop;
  logic          mem_memwrite, mem_regwrite;
  logic [RW-1:0] mem_rd;
  logic          wb_regwrite;
  logic [1:0]    wb_resultsrc;
  logic [RW-1:0] wb_rd;
  logic          pcsrc_e, stall_fd, flush_d;
  logic [1:0]    fwd_a, fwd_b;

  typedef struct packed {
    logic          v;
    logic [7:0]    ctrl;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic          zero;
  } in_t;

  typedef struct packed {
    logic          ex_alusrc;
    logic [1:0]    ex_aluop;
    logic          mem_memwrite;
    logic          mem_regwrite;
    logic [RW-1:0] mem_rd;
    logic          wb_regwrite;
    logic [1:0]    wb_resultsrc;
    logic [RW-1:0] wb_rd;
    logic          pcsrc_e;
    logic          stall_fd;
    logic          flush_d;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
  } out_t;

  typedef struct packed {
    in_t  inp;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  out_t act;
  int   errors = 0;
  int   checks = 0;

  ctrl_pipeline #(.RW(RW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_zero(ex_zero),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_resultsrc(wb_resultsrc), .wb_rd(wb_rd),
    .pcsrc_e(pcsrc_e), .stall_fd(stall_fd), .flush_d(flush_d),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  assign act = {ex_alusrc, ex_aluop, mem_memwrite, mem_regwrite, mem_rd,
                wb_regwrite, wb_resultsrc, wb_rd, pcsrc_e, stall_fd,
                flush_d, fwd_a, fwd_b};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic in_t mk_in(input int v, input int c, input int a,
                                input int b, input int d, input int z);
    in_t r;
    r.v    = 1'(v);
    r.ctrl = 8'(c);
    r.rs1  = RW'(a);
    r.rs2  = RW'(b);
    r.rd   = RW'(d);
    r.zero = 1'(z);
    return r;
  endfunction

  function automatic in_t nop();
    return mk_in(0, 0, 0, 0, 0, 0);
  endfunction

  function automatic out_t mk_out(input int alusrc, input int aluop,
                                  input int mw, input int mrw, input int mrd,
                                  input int wrw, input int wrs, input int wrd,
                                  input int pc, input int st, input int fl,
                                  input int fa, input int fb);
    out_t o;
    o.ex_alusrc    = 1'(alusrc);
    o.ex_aluop     = 2'(aluop);
    o.mem_memwrite = 1'(mw);
    o.mem_regwrite = 1'(mrw);
    o.mem_rd       = RW'(mrd);
    o.wb_regwrite  = 1'(wrw);
    o.wb_resultsrc = 2'(wrs);
    o.wb_rd        = RW'(wrd);
    o.pcsrc_e      = 1'(pc);
    o.stall_fd     = 1'(st);
    o.flush_d      = 1'(fl);
    o.fwd_a        = 2'(fa);
    o.fwd_b        = 2'(fb);
    return o;
  endfunction

  function automatic out_t oz();
    return mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf({"alusrc=%0d aluop=%0d memwrite=%0d mem_regwrite=%0d mem_rd=%0d ",
                      "wb_regwrite=%0d wb_resultsrc=%0d wb_rd=%0d pcsrc=%0d stall=%0d ",
                      "flush=%0d fwd_a=%0d fwd_b=%0d"},
                     o.ex_alusrc, o.ex_aluop, o.mem_memwrite, o.mem_regwrite,
                     o.mem_rd, o.wb_regwrite, o.wb_resultsrc, o.wb_rd,
                     o.pcsrc_e, o.stall_fd, o.flush_d, o.fwd_a, o.fwd_b);
  endfunction

  task automatic av(input in_t i, input out_t o);
    vec_t r;
    r.inp = i;
    r.exp = o;
    vecs.push_back(r);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input in_t i);
    id_valid = i.v;
    id_ctrl  = i.ctrl;
    id_rs1   = i.rs1;
    id_rs2   = i.rs2;
    id_rd    = i.rd;
    ex_zero  = i.zero;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %s | expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  // ---------------- vector table ----------------
  // ctrl encodings: load A8, add/sub 84, addi 8C, store 18, beq 03,
  // load+branch hybrid A9 (forces flush and load-use together).
  task automatic build_table();
    // load rd5, then add rs1=5: one stall cycle, one bubble, then WB forward
    av(mk_in(1, 'hA8, 1, 0, 5, 0), oz());
    av(mk_in(1, 'h84, 5, 2, 6, 0), mk_out(1,0,0,0,0, 0,0,0, 0,1,0, 0,0));
    av(mk_in(1, 'h84, 5, 2, 6, 0), mk_out(0,0,0,1,5, 0,0,0, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,2,0,0,0, 1,1,5, 0,0,0, 1,0));
    av(nop(),                      mk_out(0,0,0,1,6, 0,0,0, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,0,0,0,0, 1,0,6, 0,0,0, 0,0));
    // add rd3 -> sub rs2=3 (MEM forward); add rd3 -> addi -> sub (WB forward)
    av(mk_in(1, 'h84, 1, 2, 3, 0), oz());
    av(mk_in(1, 'h84, 4, 3, 7, 0), mk_out(0,2,0,0,0, 0,0,0, 0,0,0, 0,0));
    av(mk_in(1, 'h84, 1, 2, 3, 0), mk_out(0,2,0,1,3, 0,0,0, 0,0,0, 0,2));
    av(mk_in(1, 'h8C, 11, 12, 10, 0), mk_out(0,2,0,1,7, 1,0,3, 0,0,0, 0,0));
    av(mk_in(1, 'h84, 4, 3, 13, 0), mk_out(1,2,0,1,3, 1,0,7, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,2,0,1,10, 1,0,3, 0,0,0, 0,1));
    av(nop(),                      mk_out(0,0,0,1,13, 1,0,10, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,0,0,0,0, 1,0,13, 0,0,0, 0,0));
    // taken branch flushes a wrong-path store
    av(mk_in(1, 'h03, 1, 2, 0, 0), oz());
    av(mk_in(1, 'h18, 1, 2, 0, 1), mk_out(0,1,0,0,0, 0,0,0, 1,0,1, 0,0));
    av(mk_in(0, 0, 0, 0, 0, 1),    oz());
    av(nop(),                      oz());
    // not-taken branch: following store proceeds, memwrite 2 cycles later
    av(mk_in(1, 'h03, 1, 2, 0, 0), oz());
    av(mk_in(1, 'h18, 1, 2, 0, 0), mk_out(0,1,0,0,0, 0,0,0, 0,0,0, 0,0));
    av(nop(),                      mk_out(1,0,0,0,0, 0,0,0, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,0,1,0,0, 0,0,0, 0,0,0, 0,0));
    av(nop(),                      oz());
    // store presented with id_valid=0 never writes
    av(mk_in(0, 'h18, 5, 6, 9, 0), oz());
    av(nop(),                      oz());
    av(nop(),                      oz());
    // x0: load rd0, then uses of x0 never stall or forward
    av(mk_in(1, 'hA8, 1, 2, 0, 0), oz());
    av(mk_in(1, 'h84, 0, 0, 0, 0), mk_out(1,0,0,0,0, 0,0,0, 0,0,0, 0,0));
    av(mk_in(1, 'h84, 0, 0, 15, 0), mk_out(0,2,0,1,0, 0,0,0, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,2,0,1,0, 1,1,0, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,0,0,1,15, 1,0,0, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,0,0,0,0, 1,0,15, 0,0,0, 0,0));
    // MEM beats WB when both hold rd4; both operands forward
    av(mk_in(1, 'h84, 1, 2, 4, 0), oz());
    av(mk_in(1, 'h84, 1, 2, 4, 0), mk_out(0,2,0,0,0, 0,0,0, 0,0,0, 0,0));
    av(mk_in(1, 'h84, 4, 4, 16, 0), mk_out(0,2,0,1,4, 0,0,0, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,2,0,1,4, 1,0,4, 0,0,0, 2,2));
    av(nop(),                      mk_out(0,0,0,1,16, 1,0,4, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,0,0,0,0, 1,0,16, 0,0,0, 0,0));
    // flush wins over a simultaneous load-use
    av(mk_in(1, 'hA9, 1, 2, 5, 0), oz());
    av(mk_in(1, 'h84, 5, 0, 6, 1), mk_out(1,0,0,0,0, 0,0,0, 1,0,1, 0,0));
    av(nop(),                      mk_out(0,0,0,1,5, 0,0,0, 0,0,0, 0,0));
    av(nop(),                      mk_out(0,0,0,0,0, 1,1,5, 0,0,0, 0,0));
    av(nop(),                      oz());
    // prime the pipeline for the mid-stall reset: add rd2, store, load rd7
    av(mk_in(1, 'h84, 1, 1, 2, 0), oz());
    av(mk_in(1, 'h18, 1, 2, 0, 0), mk_out(0,2,0,0,0, 0,0,0, 0,0,0, 0,0));
    av(mk_in(1, 'hA8, 1, 0, 7, 0), mk_out(1,0,0,1,2, 0,0,0, 0,0,0, 0,2));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    build_table();

    // reset: outputs zero immediately, even with live ID inputs
    rst = 1'b1;
    drive(mk_in(1, 'hA9, 5, 5, 5, 1));
    #2;
    check("reset_async", oz());
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", oz());
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].inp);
      @(negedge clk);
      check($sformatf("row%0d", k), vecs[k].exp);
      @(posedge clk);
      #1;
    end

    // load rd7 in EX, add rs2=7 in ID: stall with store in MEM, add in WB
    drive(mk_in(1, 'h84, 0, 7, 8, 1));
    @(negedge clk);
    check("stall_before_reset", mk_out(1,0,1,0,0, 1,0,2, 0,1,0, 0,0));
    #1;
    rst = 1'b1;
    #1;
    check("reset_mid_stall", oz());
    @(posedge clk);
    #1;
    check("reset_hold", oz());
    rst = 1'b0;

    // refill: rs=7 must see neither a stall nor a forward from old state
    drive(mk_in(1, 'h84, 7, 7, 9, 0));
    @(negedge clk);
    check("refill_id", oz());
    @(posedge clk);
    #1;
    drive(nop());
    @(negedge clk);
    check("refill_ex", mk_out(0,2,0,0,0, 0,0,0, 0,0,0, 0,0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("refill_mem", mk_out(0,0,0,1,9, 0,0,0, 0,0,0, 0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 Parameter: RW, default 5, register-index width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 id_valid  in  1  decode stage holds a real instruction.
REQ-006 id_ctrl  in  8  decoded controls, bit order {regwrite, resultsrc[1:0], memwrite, alusrc, aluop[1:0], branch}.
REQ-007 id_rs1, id_rs2  in  RW each  decode source register indices.
REQ-008 id_rd  in  RW  decode destination register index.
REQ-009 ex_zero  in  1  ALU zero flag for the instruction in EX.
REQ-010 ex_alusrc  out  1  EX operand-B select.
REQ-011 ex_aluop  out  2  EX ALU operation class.
REQ-012 mem_memwrite  out  1  data-memory write enable.
REQ-013 mem_regwrite, mem_rd  out  1, RW  MEM-stage writeback intent and destination.
REQ-014 wb_regwrite, wb_resultsrc, wb_rd  out  1, 2, RW  register-file write enable, result select, destination.
REQ-015 pcsrc_e  out  1  branch taken, redirect PC.
REQ-016 stall_fd  out  1  hold PC and IF/ID register.
REQ-017 flush_d  out  1  invalidate IF/ID register.
REQ-018 fwd_a, fwd_b  out  2 each  EX operand forward select: 00 register file, 01 WB, 10 MEM.

Function
REQ-019 Three register stages SHALL exist: ID/EX, EX/MEM, MEM/WB. Each holds valid, the control fields it needs, and rd. ID/EX also holds rs1 and rs2.
REQ-020 Latency from ID to output SHALL be: ex_* 1 cycle, mem_* 2 cycles, wb_* 3 cycles.
REQ-021 A bubble SHALL be valid=0 with all control fields 0. All regwrite, memwrite and branch outputs SHALL be gated by the stage valid.
REQ-022 Load-use SHALL be detected when all of the following hold: ID/EX valid, ID/EX resultsrc==01, ID/EX rd!=0, id_valid, and ID/EX rd equals id_rs1 or id_rs2. On detection, stall_fd=1 and a bubble enters ID/EX at the next edge.
REQ-023 pcsrc_e SHALL equal ID/EX valid AND branch AND ex_zero, combinationally.
REQ-024 When pcsrc_e=1: flush_d=1, stall_fd=0, and a bubble enters ID/EX at the next edge.
REQ-025 If pcsrc_e and the load-use condition are true in the same cycle, the flush SHALL win.
REQ-026 When id_valid=0, a bubble SHALL enter ID/EX.
REQ-027 EX/MEM and MEM/WB SHALL advance every cycle and never stall.
REQ-028 fwd_a SHALL be 10 if EX/MEM valid, regwrite, rd!=0 and rd==ID/EX rs1.
REQ-029 Otherwise fwd_a SHALL be 01 if MEM/WB valid, regwrite, rd!=0 and rd==ID/EX rs1.
REQ-030 Otherwise fwd_a SHALL be 00. fwd_b SHALL follow the same rules using rs2. MEM priority exceeds WB.
REQ-031 Register index 0 SHALL never produce a forward or a stall.
REQ-032 stall_fd, flush_d, pcsrc_e, fwd_a and fwd_b SHALL be combinational from current state and ID inputs, with no added latency.

Reset
REQ-033 While rst=1, all stage registers SHALL be cleared to bubbles with rd/rs fields 0. All outputs SHALL be 0 immediately, independent of clk.
REQ-034 Deasserting rst mid-program SHALL restart from an empty pipeline. No stall or forward may derive from pre-reset state.

Verification
REQ-035 ID load (ctrl 1_01_0_1_00_0, rd=5) followed by ID add (rs1=5) -> stall_fd=1 for exactly 1 cycle, one bubble in EX, then fwd_a=01 when the add reaches EX.
REQ-036 Add rd=3 followed immediately by sub rs2=3 -> fwd_b=10 in the sub's EX cycle. With one independent instruction between them -> fwd_b=01.
REQ-037 Branch in EX with ex_zero=1 -> pcsrc_e=1, flush_d=1. The next EX cycle is a bubble: ex_aluop=00, and mem_memwrite=0 one cycle later. Same test with ex_zero=0 -> no flush.
REQ-038 Store (memwrite=1) with id_valid=1 -> mem_memwrite=1 exactly 2 cycles later for 1 cycle. Same store with id_valid=0 -> mem_memwrite stays 0.
REQ-039 Writes with rd=0, and a load with rd=0 followed by a use of x0 -> fwd_a=fwd_b=00, stall_fd=0.
REQ-040 rst asserted mid-cycle while a load-use stall is active -> stall_fd, wb_regwrite and mem_memwrite drop to 0 before the next clk edge. After release, the pipeline refills with no stale forwarding.
